sha512_msg_ctrl: RTL and testbench
==================================

// Module: sha512_msg_ctrl
// PURPOSE
// - Initiator-side driver for sha512_core: accepts a byte-aligned message as 64-bit big-endian words,
//   packs 1024-bit blocks, applies SHA-512 padding and length, and issues i_start/i_data/i_vin to the core.
// - Chains o_vout into the next block's i_vin and presents the final 512-bit digest.
// - Sits between a word-stream source and one sha512_core instance.
// PARAMETERS
// - LEN_W  64  message byte-counter width; the 128-bit length field is {zero-fill, byte_cnt, 3'b000}
// PORTS
// - i_clk           in   1     single clock, rising edge
// - i_rst           in   1     asynchronous, active-high reset
// - i_init          in   1     1-cycle pulse: begin new message (accepted only in IDLE or DONE)
// - i_valid         in   1     input word valid
// - i_data          in   64    message word, first byte in [63:56]
// - i_last          in   1     final word of message
// - i_bytes         in   4     valid bytes in last word, 0..8; 0 only for an empty tail; ignored unless i_last
// - o_ready         out  1     word accepted when i_valid && o_ready
// - o_core_start    out  1     1-cycle start pulse to core
// - o_core_data     out  1024  block to core, word 0 in [1023:960]
// - o_core_vin      out  512   chaining value to core
// - i_core_vout     in   512   core result
// - i_core_done     in   1     core completion flag
// - o_digest        out  512   final hash, H0 in [511:448]
// - o_digest_valid  out  1     high from digest capture until next i_init
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0, buffer 0. Reset mid-message aborts everything.
// - States: IDLE -> FILL (i_init) -> HASH -> FILL, or PAD -> HASH_PAD -> DONE; DONE -> FILL (i_init).
// - FILL: o_ready=1; accepted word goes to buf[widx]; widx++, byte_cnt += 8 (or i_bytes on last).
// - Buffer full (widx wraps 15->0) without i_last -> HASH. Full with i_last -> HASH with pad_pend=1.
// - HASH:
//   - o_core_start pulses on the first cycle; o_core_vin = H_INIT for the first block, else chain reg.
//   - o_core_data/o_core_vin held stable until i_core_done.
//   - On done, latch chain <= i_core_vout; go to FILL, or PAD if pad_pend.
// - i_last with i_bytes<8 (partial word): the word is masked to its valid bytes; 0x80 goes in the
//   byte following the last valid byte of the same word.
// - i_last with i_bytes=8: 0x80 goes in [63:56] of word widx+1.
// - Padding length: let p = index of the word holding 0x80.
//   - p<=13: single final block; zeros to word 13, length in words 14-15.
//   - p>=14: current block zero-filled and hashed; extra block of zeros + length.
//   - Pad-pending after a full block: next block = 0x80 at word 0 + zeros + length.
// - o_ready=0 outside FILL; i_valid ignored there. i_init outside IDLE/DONE ignored.
// - i_init in DONE clears o_digest_valid, byte_cnt, widx, and the first-block flag.
// - i_valid with i_init on the same cycle: the word is ignored; data is accepted from the next cycle.
// - Final HASH_PAD done: o_digest <= i_core_vout, o_digest_valid=1, state DONE.
// - i_core_done is sampled only in HASH/HASH_PAD; a stale done level from a previous block is
//   ignored for 1 cycle after start.
// - byte_cnt wraps modulo 2^LEN_W; no overflow flag.
// STRUCTURE
// - sha512_pkg: H_INIT 512-bit constant, state encodings, BLK_W=1024, WORD_W=64, LEN_FIELD_W=128.
// - Sub-module sha512_pad_word: combinational (word, nbytes) -> masked word with 0x80 inserted.
//   Also used for the i_bytes=8 next-word case.
// TESTING (bench wires a real sha512_core)
// - "abc": i_data=64'h6162630000000000, i_last, i_bytes=3
//   -> one block with len 0x18; digest ddaf35a1...a54ca49f.
// - Empty message: i_init then i_last with i_bytes=0
//   -> block 0x80..0, len 0; digest cf83e135...f927da3e.
// - 160-byte "1234567890"x16
//   -> 2 core starts, second block len 0x500; digest 72bf7945...1b1b0234.
// - 112-byte "abcdefghbcdefghi...nopqrstu" (p=14)
//   -> 2 core starts, second block zeros + len 0x380; digest 8e959b75...874be909.
// - Exactly 128 bytes -> 2 starts, second block 0x80 at word 0; chaining vin equals first vout.
// - Assert i_rst during HASH -> all outputs 0 next cycle; then a new "abc" message gives the
//   correct digest. Also check o_ready=0 during HASH.

Source files
------------

// File: rtl/sha512_pkg.sv
// sha512_pkg: shared widths, FSM encoding and the SHA-512 initial hash value
package sha512_pkg;

   localparam int BLK_W       = 1024;
   localparam int WORD_W      = 64;
   localparam int DIG_W       = 512;
   localparam int LEN_FIELD_W = 128;

   localparam logic [DIG_W-1:0] H_INIT = {
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_HASH,
      ST_PAD,
      ST_HASH_PAD,
      ST_DONE
   } state_e;

endpackage

// File: rtl/sha512_pad_word.sv
// sha512_pad_word: keeps the first i_nbytes bytes of a big-endian word and places 0x80 right after them
module sha512_pad_word
   import sha512_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   input  logic [3:0]        i_nbytes,
   output logic [WORD_W-1:0] o_word
);

   for (genvar b = 0; b < 8; b++) begin : g_byte
      assign o_word[WORD_W-1-8*b -: 8] = (4'(b) < i_nbytes)  ? i_word[WORD_W-1-8*b -: 8] :
                                         (4'(b) == i_nbytes) ? 8'h80 : 8'h00;
   end

endmodule

// File: rtl/sha512_msg_ctrl.sv
// sha512_msg_ctrl: packs a 64-bit word stream into padded 1024-bit blocks and sequences one sha512_core,
// chaining each block's result into the next and capturing the final digest.
module sha512_msg_ctrl
   import sha512_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_init,
   input  logic               i_valid,
   input  logic [WORD_W-1:0]  i_data,
   input  logic               i_last,
   input  logic [3:0]         i_bytes,
   output logic               o_ready,
   output logic               o_core_start,
   output logic [BLK_W-1:0]   o_core_data,
   output logic [DIG_W-1:0]   o_core_vin,
   input  logic [DIG_W-1:0]   i_core_vout,
   input  logic               i_core_done,
   output logic [DIG_W-1:0]   o_digest,
   output logic               o_digest_valid
);

   state_e                        state_q, state_d;
   logic [15:0][WORD_W-1:0]       buf_q, buf_d;
   logic [3:0]                    widx_q, widx_d;
   logic [LEN_W-1:0]              byte_cnt_q, byte_cnt_d;
   logic [4:0]                    p_q, p_d;
   logic                          pad_pend_q, pad_pend_d;
   logic                          first_q, first_d;
   logic                          start_q, start_d;
   logic [DIG_W-1:0]              chain_q, chain_d;
   logic [DIG_W-1:0]              digest_q, digest_d;
   logic                          digest_valid_q, digest_valid_d;
   logic [WORD_W-1:0]             last_word, mark_word;
   logic [LEN_FIELD_W-1:0]        len_field;
   logic [3:0]                    widx_nx;
   logic                          core_done;

   // Word i of the block lives in buf slot 15-i (== ~i), so buf_q maps straight onto o_core_data
   sha512_pad_word u_last (.i_word(i_data), .i_nbytes(i_bytes), .o_word(last_word));
   sha512_pad_word u_mark (.i_word('0),     .i_nbytes(4'd0),    .o_word(mark_word));

   assign widx_nx   = widx_q + 4'd1;
   assign len_field = {{(LEN_FIELD_W-LEN_W-3){1'b0}}, byte_cnt_q, 3'b000};
   // The start cycle may still see the previous block's done level
   assign core_done = (state_q == ST_HASH || state_q == ST_HASH_PAD) && i_core_done && !start_q;

   always_comb begin
      state_d        = state_q;
      buf_d          = buf_q;
      widx_d         = widx_q;
      byte_cnt_d     = byte_cnt_q;
      p_d            = p_q;
      pad_pend_d     = pad_pend_q;
      first_d        = first_q;
      start_d        = 1'b0;
      chain_d        = chain_q;
      digest_d       = digest_q;
      digest_valid_d = digest_valid_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (i_init) begin
               state_d        = ST_FILL;
               widx_d         = '0;
               byte_cnt_d     = '0;
               first_d        = 1'b1;
               pad_pend_d     = 1'b0;
               digest_valid_d = 1'b0;
            end
         end
         ST_FILL: begin
            if (i_valid) begin
               widx_d = widx_nx;
               if (!i_last) begin
                  buf_d[~widx_q] = i_data;
                  byte_cnt_d     = byte_cnt_q + LEN_W'(8);
                  state_d        = (widx_q == 4'd15) ? ST_HASH : ST_FILL;
                  start_d        = (widx_q == 4'd15);
               end else begin
                  buf_d[~widx_q] = last_word;
                  byte_cnt_d     = byte_cnt_q + LEN_W'(i_bytes);
                  if (i_bytes[3] && widx_q != 4'd15)
                     buf_d[~widx_nx] = mark_word;
                  // p = index of the word carrying 0x80; 16 means it spills into the next block
                  p_d        = {1'b0, widx_q} + 5'(i_bytes[3]);
                  pad_pend_d = (widx_q == 4'd15);
                  state_d    = (widx_q == 4'd15) ? ST_HASH : ST_PAD;
                  start_d    = (widx_q == 4'd15);
               end
            end
         end
         ST_PAD: begin
            for (int s = 0; s < 16; s++)
               buf_d[4'(s)] = (15 - s <= int'(p_q)) ? buf_q[4'(s)] : '0;
            if (p_q <= 5'd13) begin
               buf_d[1:0] = len_field;
               state_d    = ST_HASH_PAD;
            end else begin
               pad_pend_d = 1'b1;
               state_d    = ST_HASH;
            end
            start_d = 1'b1;
         end
         ST_HASH: begin
            if (core_done) begin
               chain_d = i_core_vout;
               first_d = 1'b0;
               if (pad_pend_q) begin
                  // Length-only block, with the marker at word 0 if it did not fit before
                  buf_d      = '0;
                  buf_d[15]  = p_q[4] ? mark_word : '0;
                  p_d        = '0;
                  pad_pend_d = 1'b0;
                  state_d    = ST_PAD;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end
         ST_HASH_PAD: begin
            if (core_done) begin
               chain_d        = i_core_vout;
               first_d        = 1'b0;
               digest_d       = i_core_vout;
               digest_valid_d = 1'b1;
               state_d        = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q        <= ST_IDLE;
         buf_q          <= '0;
         widx_q         <= '0;
         byte_cnt_q     <= '0;
         p_q            <= '0;
         pad_pend_q     <= 1'b0;
         first_q        <= 1'b0;
         start_q        <= 1'b0;
         chain_q        <= '0;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         buf_q          <= buf_d;
         widx_q         <= widx_d;
         byte_cnt_q     <= byte_cnt_d;
         p_q            <= p_d;
         pad_pend_q     <= pad_pend_d;
         first_q        <= first_d;
         start_q        <= start_d;
         chain_q        <= chain_d;
         digest_q       <= digest_d;
         digest_valid_q <= digest_valid_d;
      end
   end

   assign o_ready        = (state_q == ST_FILL);
   assign o_core_start   = start_q;
   assign o_core_data    = buf_q;
   assign o_core_vin     = first_q ? H_INIT : chain_q;
   assign o_digest       = digest_q;
   assign o_digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha512_msg_ctrl.sv
// tb_sha512_msg_ctrl: drives directed messages through sha512_msg_ctrl against a behavioural SHA-512 core
// and checks blocks, chaining values and digests against a software padding/compression model.
module tb_sha512_msg_ctrl;

   logic          i_clk, i_rst, i_init, i_valid, i_last;
   logic [63:0]   i_data;
   logic [3:0]    i_bytes;
   logic          o_ready, o_core_start, o_digest_valid;
   logic [1023:0] o_core_data;
   logic [511:0]  o_core_vin, o_digest;
   logic [511:0]  core_vout, core_res, cur_vin;
   logic [1023:0] cur_blk;
   logic          core_done;
   int            core_cnt = 0;
   int            starts = 0;
   int            checks = 0;
   int            errors = 0;
   logic [1023:0] blk_log [16];
   logic [511:0]  vin_log [16];
   logic [511:0]  vout_log [16];
   logic [7:0]    msg [256];

   localparam logic [511:0] H0 = {
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
   };

   localparam logic [63:0] K [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   sha512_msg_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_valid(i_valid), .i_data(i_data),
      .i_last(i_last), .i_bytes(i_bytes), .o_ready(o_ready), .o_core_start(o_core_start),
      .o_core_data(o_core_data), .o_core_vin(o_core_vin), .i_core_vout(core_vout),
      .i_core_done(core_done), .o_digest(o_digest), .o_digest_valid(o_digest_valid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [511:0] sha512_compress(input logic [511:0] v, input logic [1023:0] blk);
      logic [63:0] w [80];
      logic [63:0] a, b, c, d, e, f, g, h, t1, t2;
      logic [511:0] r;
      for (int i = 0; i < 16; i++) w[i] = blk[1023-64*i -: 64];
      for (int i = 16; i < 80; i++)
         w[i] = (ror(w[i-2], 19) ^ ror(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7] +
                (ror(w[i-15], 1) ^ ror(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
      {a, b, c, d, e, f, g, h} = v;
      for (int i = 0; i < 80; i++) begin
         t1 = h + (ror(e, 14) ^ ror(e, 18) ^ ror(e, 41)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
         t2 = (ror(a, 28) ^ ror(a, 34) ^ ror(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      r = {a, b, c, d, e, f, g, h};
      for (int k = 0; k < 8; k++) r[511-64*k -: 64] = r[511-64*k -: 64] + v[511-64*k -: 64];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      int k;
      checks++;
      assert (obs === exp) else begin
         errors++;
         k = 15;
         for (int i = 0; i < 16; i++) if (obs[1023-64*i -: 64] !== exp[1023-64*i -: 64]) k = i;
         $error("FAIL %s: word %0d observed %0h expected %0h", tag, k, obs[1023-64*k -: 64], exp[1023-64*k -: 64]);
      end
   endtask

   // Behavioural core: result and done appear 5 cycles after start; done stays high until the next start
   always @(posedge i_clk) begin
      if (i_rst) begin
         core_done <= 1'b0;
         core_cnt  <= 0;
         core_vout <= '0;
      end else if (o_core_start) begin
         core_done             <= 1'b0;
         core_cnt              <= 4;
         core_res              <= sha512_compress(o_core_vin, o_core_data);
         cur_blk               <= o_core_data;
         cur_vin               <= o_core_vin;
         blk_log[starts % 16]  <= o_core_data;
         vin_log[starts % 16]  <= o_core_vin;
         starts                <= starts + 1;
      end else if (core_cnt > 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) begin
            core_done                  <= 1'b1;
            core_vout                  <= core_res;
            vout_log[(starts - 1) % 16] <= core_res;
         end
      end
   end

   always @(negedge i_clk) begin
      if (!i_rst && core_cnt == 1) begin
         chk("hold data", o_core_data, cur_blk);
         chk("hold vin", o_core_vin, cur_vin);
      end
   end

   task automatic put_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
      int t = 0;
      i_valid = 1'b1; i_data = d; i_last = l; i_bytes = nb;
      while (!o_ready && t < 200) begin @(negedge i_clk); t++; end
      if (t >= 200) chk("ready timeout", o_ready, 1);
      @(negedge i_clk);
      i_valid = 1'b0; i_last = 1'b0;
   endtask

   task automatic pulse_init();
      i_init = 1'b1; i_valid = 1'b1; i_data = '1; i_last = 1'b1; i_bytes = 4'd8;
      @(negedge i_clk);
      i_init = 1'b0; i_valid = 1'b0; i_last = 1'b0;
   endtask

   task automatic run_msg(input int len, input bit known, input logic [511:0] exp_dig, input string tag);
      int base, nblk, nw, t;
      logic [7:0] pm [384];
      logic [1023:0] eb;
      logic [511:0] h;
      logic [63:0] wd;
      nblk = (len + 17 + 127) / 128;
      for (int i = 0; i < 384; i++) pm[i] = (i < len) ? msg[i] : (i == len) ? 8'h80 : 8'h00;
      for (int k = 0; k < 8; k++) pm[nblk*128-1-k] = 8'((64'(len) << 3) >> (8 * k));
      base = starts;
      pulse_init();
      chk({tag, " dvalid clr"}, o_digest_valid, 0);
      nw = (len == 0) ? 1 : (len + 7) / 8;
      for (int j = 0; j < nw; j++) begin
         if (j == 1) begin
            i_init = 1'b1;
            @(negedge i_clk);
            i_init = 1'b0;
         end
         for (int b = 0; b < 8; b++) wd[63-8*b -: 8] = (8*j + b < len) ? msg[8*j + b] : 8'hA5;
         put_word(wd, j == nw - 1, 4'(len - 8 * (nw - 1)));
      end
      t = 0;
      while (!o_digest_valid && t < 1000) begin @(negedge i_clk); t++; end
      chk({tag, " dvalid"}, o_digest_valid, 1);
      chk({tag, " starts"}, 1024'(starts - base), 1024'(nblk));
      h = H0;
      for (int k = 0; k < nblk; k++) begin
         for (int i = 0; i < 128; i++) eb[1023-8*i -: 8] = pm[128*k + i];
         chk($sformatf("%s blk%0d", tag, k), blk_log[(base + k) % 16], eb);
         chk($sformatf("%s vin%0d", tag, k), vin_log[(base + k) % 16], h);
         if (k > 0) chk($sformatf("%s chain%0d", tag, k), vin_log[(base + k) % 16], vout_log[(base + k - 1) % 16]);
         h = sha512_compress(h, eb);
      end
      chk({tag, " digest"}, o_digest, h);
      if (known) chk({tag, " digest ref"}, o_digest, exp_dig);
   endtask

   task automatic load_abc();
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
   endtask

   initial begin
      int t;
      i_rst = 1'b1; i_init = 1'b0; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_bytes = '0;
      repeat (3) @(negedge i_clk);
      chk("rst ready", o_ready, 0);
      chk("rst start", o_core_start, 0);
      chk("rst data", o_core_data, 0);
      chk("rst vin", o_core_vin, 0);
      chk("rst digest", o_digest, 0);
      chk("rst dvalid", o_digest_valid, 0);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("idle ready", o_ready, 0);

      load_abc();
      run_msg(3, 1'b1, 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f, "abc");
      run_msg(0, 1'b1, 512'hcf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e, "empty");

      for (int i = 0; i < 160; i++) msg[i] = 8'h30 + 8'((i + 1) % 10);
      run_msg(160, 1'b0, '0, "digits160");

      for (int g = 0; g < 14; g++)
         for (int b = 0; b < 8; b++) msg[8*g + b] = 8'h61 + 8'(g + b);
      run_msg(112, 1'b1, 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909, "p14");

      for (int i = 0; i < 128; i++) msg[i] = 8'(i * 7 + 3);
      run_msg(128, 1'b0, '0, "full128");
      run_msg(124, 1'b0, '0, "p15");
      run_msg(111, 1'b0, '0, "p13");

      for (int i = 0; i < 160; i++) msg[i] = 8'h30 + 8'((i + 1) % 10);
      pulse_init();
      for (int j = 0; j < 16; j++) put_word({msg[8*j], msg[8*j+1], msg[8*j+2], msg[8*j+3], msg[8*j+4], msg[8*j+5], msg[8*j+6], msg[8*j+7]}, 1'b0, 4'd8);
      t = 0;
      while (!o_core_start && t < 100) begin @(negedge i_clk); t++; end
      chk("hash start", o_core_start, 1);
      @(negedge i_clk);
      chk("hash ready", o_ready, 0);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("mid rst ready", o_ready, 0);
      chk("mid rst start", o_core_start, 0);
      chk("mid rst data", o_core_data, 0);
      chk("mid rst vin", o_core_vin, 0);
      chk("mid rst digest", o_digest, 0);
      chk("mid rst dvalid", o_digest_valid, 0);
      i_rst = 1'b0;
      @(negedge i_clk);
      load_abc();
      run_msg(3, 1'b1, 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f, "abc after rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
